// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pipe_ctrl_pkg
// Brief    : Shared types and constants for the 5-stage pipeline sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [15:0] NOP_INSTR            = 16'h0800;
    localparam int          DEFAULT_REG_W        = 3;
    localparam int          DEFAULT_DRAIN_CYCLES = 3;
    localparam int          DEFAULT_CNT_W        = 16;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : pipe_hazard_ctrl_if
// Brief     : Hazard inputs and stage-register controls between datapath
//             (master) and pipeline sequencer (slave).
// Revision  : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs;
    logic             id_rs_used;
    logic [REG_W-1:0] id_rt;
    logic             id_rt_used;
    logic             id_halt;
    logic [REG_W-1:0] ex_rd;
    logic             ex_memread;
    logic             ex_br_taken;
    logic             imem_stall;
    logic             dmem_stall;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_nop;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_en;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rs_used, id_rt, id_rt_used, id_halt,
               ex_rd, ex_memread, ex_br_taken, imem_stall, dmem_stall,
        input  pc_en, ifid_en, ifid_nop, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_en, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rs_used, id_rt, id_rt_used, id_halt,
               ex_rd, ex_memread, ex_br_taken, imem_stall, dmem_stall,
        output pc_en, ifid_en, ifid_nop, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_en, halted, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Brief    : Combinational load-use compare of ID sources against EX load dest.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect #(
    parameter int REG_W = 3
) (
    input  wire logic [REG_W-1:0] i_id_rs,
    input  wire logic             i_id_rs_used,
    input  wire logic [REG_W-1:0] i_id_rt,
    input  wire logic             i_id_rt_used,
    input  wire logic [REG_W-1:0] i_ex_rd,
    input  wire logic             i_ex_memread,
    output logic                  o_load_use
);
    logic w_rs_hit;
    logic w_rt_hit;

    // Full-width compare; R0 is deliberately treated like any other register.
    assign w_rs_hit   = i_id_rs_used && (i_id_rs == i_ex_rd);
    assign w_rt_hit   = i_id_rt_used && (i_id_rt == i_ex_rd);
    assign o_load_use = i_ex_memread && (w_rs_hit || w_rt_hit);
endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Pipeline sequencer: stalls, bubbles, flushes and HALT drain/freeze.
//            PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W        = DEFAULT_REG_W,
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int C_DC_W = $clog2(DRAIN_CYCLES + 1);

    state_t              r_state;
    logic [C_DC_W-1:0]   r_drain_cnt;

    logic w_load_use;
    logic w_halt_req;
    logic w_pc_en, w_ifid_en, w_ifid_nop, w_ifid_flush;
    logic w_idex_en, w_idex_flush, w_exmem_en, w_memwb_en, w_halted;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .i_id_rs      (bus.id_rs),
        .i_id_rs_used (bus.id_rs_used),
        .i_id_rt      (bus.id_rt),
        .i_id_rt_used (bus.id_rt_used),
        .i_ex_rd      (bus.ex_rd),
        .i_ex_memread (bus.ex_memread),
        .o_load_use   (w_load_use)
    );

    always_comb begin
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_ifid_nop   = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_en    = 1'b1;
        w_idex_flush = 1'b0;
        w_exmem_en   = 1'b1;
        w_memwb_en   = 1'b1;
        w_halted     = 1'b0;
        w_halt_req   = 1'b0;
        if (rst) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_en    = 1'b0;
            w_exmem_en   = 1'b0;
            w_memwb_en   = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.dmem_stall) begin
                        // MEM/WB keeps moving so the stalled load leaves a bubble behind it.
                        w_pc_en    = 1'b0;
                        w_ifid_en  = 1'b0;
                        w_idex_en  = 1'b0;
                        w_exmem_en = 1'b0;
                    end else if (bus.ex_br_taken) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_en      = 1'b0;
                        w_ifid_en    = 1'b0;
                        w_idex_flush = 1'b1;
                    end else if (bus.imem_stall) begin
                        w_pc_en    = 1'b0;
                        w_ifid_nop = 1'b1;
                    end else if (bus.id_halt) begin
                        w_pc_en    = 1'b0;
                        w_ifid_nop = 1'b1;
                        w_halt_req = 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.dmem_stall) begin
                        w_pc_en    = 1'b0;
                        w_ifid_en  = 1'b0;
                        w_idex_en  = 1'b0;
                        w_exmem_en = 1'b0;
                    end else begin
                        w_pc_en      = 1'b0;
                        w_ifid_nop   = 1'b1;
                        w_idex_flush = 1'b1;
                    end
                end
                HALTED: begin
                    w_pc_en    = 1'b0;
                    w_ifid_en  = 1'b0;
                    w_idex_en  = 1'b0;
                    w_exmem_en = 1'b0;
                    w_memwb_en = 1'b0;
                    w_halted   = 1'b1;
                end
                default: begin
                    w_pc_en    = 1'b0;
                    w_ifid_en  = 1'b0;
                    w_idex_en  = 1'b0;
                    w_exmem_en = 1'b0;
                    w_memwb_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_halt_req) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= C_DC_W'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    if (!bus.dmem_stall) begin
                        if (r_drain_cnt == C_DC_W'(1)) begin
                            r_state <= HALTED;
                        end
                        r_drain_cnt <= r_drain_cnt - C_DC_W'(1);
                    end
                end
                HALTED: r_state <= HALTED;
                default: begin
                    r_state     <= RUN;
                    r_drain_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.pc_en      = w_pc_en;
    assign bus.ifid_en    = w_ifid_en;
    assign bus.ifid_nop   = w_ifid_nop;
    assign bus.ifid_flush = w_ifid_flush;
    assign bus.idex_en    = w_idex_en;
    assign bus.idex_flush = w_idex_flush;
    assign bus.exmem_en   = w_exmem_en;
    assign bus.memwb_en   = w_memwb_en;
    assign bus.halted     = w_halted;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_inc;
    logic             w_br_flush;

    assign w_stall_inc = ((r_state == RUN) || (r_state == DRAIN)) && !w_pc_en;
    assign w_br_flush  = (r_state == RUN) && !bus.dmem_stall && bus.ex_br_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_br_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Scoreboard bench for pipe_hazard_ctrl (control vector per cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    localparam int REG_W = 3;
    localparam int CNT_W = 16;
`ifdef PIPE_CTRL_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    // Vector order: pc,ifid_en,ifid_nop,ifid_flush,idex_en,idex_flush,exmem,memwb,halted
    localparam logic [8:0] E_RST    = 9'b000101000;
    localparam logic [8:0] E_RUN    = 9'b110010110;
    localparam logic [8:0] E_DMEM   = 9'b000000010;
    localparam logic [8:0] E_BR     = 9'b110111110;
    localparam logic [8:0] E_LU     = 9'b000011110;
    localparam logic [8:0] E_IMEM   = 9'b011010110;
    localparam logic [8:0] E_HALT   = 9'b011010110;
    localparam logic [8:0] E_DRAIN  = 9'b011011110;
    localparam logic [8:0] E_HALTED = 9'b000000001;

    typedef struct packed {
        logic [2:0] id_rs;
        logic       rs_used;
        logic [2:0] id_rt;
        logic       rt_used;
        logic       halt;
        logic [2:0] ex_rd;
        logic       memread;
        logic       br;
        logic       imem;
        logic       dmem;
    } in_t;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic in_t mk(int rs, bit rsu, int rt, bit rtu, bit halt,
                               int rd, bit mr, bit br, bit imem, bit dmem);
        in_t s;
        s.id_rs = 3'(rs);  s.rs_used = rsu;
        s.id_rt = 3'(rt);  s.rt_used = rtu;
        s.halt  = halt;    s.ex_rd   = 3'(rd);
        s.memread = mr;    s.br = br;
        s.imem  = imem;    s.dmem = dmem;
        return s;
    endfunction

    function automatic logic [8:0] obs();
        return {bus.pc_en, bus.ifid_en, bus.ifid_nop, bus.ifid_flush, bus.idex_en,
                bus.idex_flush, bus.exmem_en, bus.memwb_en, bus.halted};
    endfunction

    task automatic apply(input in_t s);
        bus.id_rs       = s.id_rs;
        bus.id_rs_used  = s.rs_used;
        bus.id_rt       = s.id_rt;
        bus.id_rt_used  = s.rt_used;
        bus.id_halt     = s.halt;
        bus.ex_rd       = s.ex_rd;
        bus.ex_memread  = s.memread;
        bus.ex_br_taken = s.br;
        bus.imem_stall  = s.imem;
        bus.dmem_stall  = s.dmem;
    endtask

    // Drive at the falling edge, leave the result on the scoreboard for sampling
    // one time unit before the next rising edge.
    task automatic step(input in_t s, input string nm, input logic [8:0] e);
        @(negedge clk);
        apply(s);
        sb.push_back('{nm, e});
        #4;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        apply('0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sb_t e;
        apply('0);
        @(negedge clk);
        sb.push_back('{"rst_initial", E_RST});
        e = sb.pop_front(); checks++;
        if (obs() !== e.exp) begin
            errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
        end
        rst = 1'b0;
        #4;
        step(mk(0,0,0,0,1,0,0,0,0,0), "rst_halt_entry", E_HALT);
        e = sb.pop_front(); checks++;
        if (obs() !== e.exp) begin
            errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
        end
        step('0, "rst_drain_first", E_DRAIN);
        e = sb.pop_front(); checks++;
        if (obs() !== e.exp) begin
            errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
        end
        // drain_cnt is now 2; reset must override the DRAIN outputs immediately
        @(negedge clk);
        apply('0);
        #2 rst = 1'b1;
        sb.push_back('{"rst_mid_drain", E_RST});
        #1;
        e = sb.pop_front(); checks++;
        if (obs() !== e.exp) begin
            errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step('0, "rst_release_run", E_RUN);
            e = sb.pop_front(); checks++;
            if (obs() !== e.exp) begin
                errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
            end
        end
        checks++;
        if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_counters: got stall %0d flush %0d want 0 0", bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_load_use();
        in_t        st[8];
        string      nm[8];
        logic [8:0] ex[8];
        sb_t        e;
        st[0] = mk(3,1,0,0,0,3,1,0,0,0); nm[0] = "lu_rs_match";     ex[0] = E_LU;
        st[1] = mk(3,1,0,0,0,3,0,0,0,0); nm[1] = "lu_released";     ex[1] = E_RUN;
        st[2] = mk(1,0,5,1,0,5,1,0,0,0); nm[2] = "lu_rt_match";     ex[2] = E_LU;
        st[3] = mk(5,0,5,0,0,5,1,0,0,0); nm[3] = "lu_unused_srcs";  ex[3] = E_RUN;
        st[4] = mk(3,1,3,1,0,7,1,0,0,0); nm[4] = "lu_msb_differs";  ex[4] = E_RUN;
        st[5] = mk(0,1,0,0,0,0,1,0,0,0); nm[5] = "lu_r0_match";     ex[5] = E_LU;
        st[6] = mk(2,1,0,0,0,2,1,0,1,0); nm[6] = "lu_over_imem";    ex[6] = E_LU;
        st[7] = mk(2,1,0,0,0,2,0,0,0,0); nm[7] = "lu_after_run";    ex[7] = E_RUN;
        for (int i = 0; i < 8; i++) begin
            step(st[i], nm[i], ex[i]);
            e = sb.pop_front(); checks++;
            if (obs() !== e.exp) begin
                errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
            end
        end
    endtask

    task automatic test_branch_priority();
        in_t        st[4];
        string      nm[4];
        logic [8:0] ex[4];
        sb_t        e;
        do_reset();
        st[0] = mk(3,1,0,0,1,3,1,1,0,0); nm[0] = "br_over_halt_lu"; ex[0] = E_BR;
        st[1] = '0;                      nm[1] = "br_stays_run";    ex[1] = E_RUN;
        st[2] = mk(0,0,0,0,0,0,0,1,0,1); nm[2] = "dmem_over_br";    ex[2] = E_DMEM;
        st[3] = '0;                      nm[3] = "dmem_released";   ex[3] = E_RUN;
        for (int i = 0; i < 4; i++) begin
            step(st[i], nm[i], ex[i]);
            e = sb.pop_front(); checks++;
            if (obs() !== e.exp) begin
                errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
            end
        end
        checks++;
        if (bus.flush_cnt !== 16'(PERF)) begin
            errors++; $display("FAIL flush_cnt: got %0d want %0d", bus.flush_cnt, PERF);
        end
        checks++;
        if (bus.stall_cnt !== 16'(PERF)) begin
            errors++; $display("FAIL stall_cnt_br: got %0d want %0d", bus.stall_cnt, PERF);
        end
    endtask

    task automatic test_halt_drain();
        in_t        st[10];
        string      nm[10];
        logic [8:0] ex[10];
        sb_t        e;
        do_reset();
        st[0] = mk(0,0,0,0,1,0,0,0,0,0); nm[0] = "halt_enter";    ex[0] = E_HALT;
        st[1] = '0;                      nm[1] = "drain_1";       ex[1] = E_DRAIN;
        st[2] = mk(0,0,0,0,0,0,0,0,0,1); nm[2] = "drain_dmem_a";  ex[2] = E_DMEM;
        st[3] = mk(0,0,0,0,0,0,0,0,0,1); nm[3] = "drain_dmem_b";  ex[3] = E_DMEM;
        st[4] = '0;                      nm[4] = "drain_2";       ex[4] = E_DRAIN;
        st[5] = '0;                      nm[5] = "drain_3";       ex[5] = E_DRAIN;
        st[6] = '0;                      nm[6] = "halted_idle";   ex[6] = E_HALTED;
        st[7] = mk(3,1,0,0,1,3,1,1,0,0); nm[7] = "halted_br";     ex[7] = E_HALTED;
        st[8] = mk(0,0,0,0,0,0,0,0,1,0); nm[8] = "halted_imem";   ex[8] = E_HALTED;
        st[9] = mk(0,0,0,0,0,0,0,0,0,1); nm[9] = "halted_dmem";   ex[9] = E_HALTED;
        for (int i = 0; i < 10; i++) begin
            step(st[i], nm[i], ex[i]);
            e = sb.pop_front(); checks++;
            if (obs() !== e.exp) begin
                errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
            end
        end
        do_reset();
        step('0, "halt_exit_by_rst", E_RUN);
        e = sb.pop_front(); checks++;
        if (obs() !== e.exp) begin
            errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
        end
    endtask

    task automatic test_imem_stall();
        sb_t e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(mk(0,0,0,0,0,0,0,0,1,0), "imem_stall", E_IMEM);
            else       step('0, "imem_released", E_RUN);
            e = sb.pop_front(); checks++;
            if (obs() !== e.exp) begin
                errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
            end
        end
        checks++;
        if (bus.stall_cnt !== 16'(4 * PERF)) begin
            errors++; $display("FAIL stall_cnt_imem: got %0d want %0d", bus.stall_cnt, 4 * PERF);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_halt_drain();
        test_imem_stall();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
